reg_wr_arbiter: RTL and testbench

Write-port arbiter and load sequencer for the bank of 8-bit parallel-load registers (`reg8_S5` instances) in the microprocessor datapath. Two requesters, e.g. the ALU result path and the memory-load path, compete for register writes. The block grants one write at a time using round-robin priority. It drives the per-register `pl` load strobes and the shared write-data bus, so exactly one register loads per granted write.

---
 rtl/reg_wr_arbiter.sv | 105 ++++++++++
 tb/tb_reg_wr_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wr_arbiter.sv
// Round-robin write-port arbiter for a bank of parallel-load registers: grants one of two
// requesters per write, drives the one-hot load strobes and the shared write-data bus.
module reg_wr_arbiter #(
  parameter int unsigned NREG = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0,
  input  logic [AW-1:0]   addr0,
  input  logic [W-1:0]    data0,
  output logic            gnt0,
  input  logic            req1,
  input  logic [AW-1:0]   addr1,
  input  logic [W-1:0]    data1,
  output logic            gnt1,
  output logic [NREG-1:0] pl,
  output logic [W-1:0]    wdata,
  output logic            busy,
  output logic            err
);

  typedef enum logic [0:0] {StIdle, StWrite} state_e;

  state_e          state_q, state_d;
  logic            rr_q, rr_d;
  logic            gnt0_q, gnt0_d;
  logic            gnt1_q, gnt1_d;
  logic [NREG-1:0] pl_q, pl_d;
  logic [W-1:0]    wdata_q, wdata_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  logic            win1;
  logic [AW-1:0]   win_addr;
  logic            in_range;

  // Requester 1 wins when alone, or when both request and the pointer favours it.
  assign win1     = req1 & (~req0 | rr_q);
  assign win_addr = win1 ? addr1 : addr0;
  assign in_range = 32'(win_addr) < NREG;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    pl_d    = '0;
    wdata_d = wdata_q;
    busy_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req0 | req1) begin
          state_d = StWrite;
          gnt0_d  = ~win1;
          gnt1_d  = win1;
          wdata_d = win1 ? data1 : data0;
          pl_d    = in_range ? (NREG'(1) << win_addr) : '0;
          err_d   = ~in_range;
          busy_d  = 1'b1;
          // Pointer moves to the loser even if it was not requesting.
          rr_d    = ~win1;
        end
      end
      StWrite: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      rr_q    <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      pl_q    <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      pl_q    <= pl_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign pl    = pl_q;
  assign wdata = wdata_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Bench for reg_wr_arbiter: queue-driven requesters, a transaction-level arbitration model
// feeding a scoreboard, and a modelled register bank loaded from pl/wdata.
module tb_reg_wr_arbiter;
  localparam int unsigned NREG = 4;
  localparam int unsigned W    = 8;
  localparam int unsigned AW   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [W-1:0] data0 = '0, data1 = '0;
  logic gnt0, gnt1, busy, err;
  logic [NREG-1:0] pl;
  logic [W-1:0] wdata;

  // Second instance with a non-power-of-two bank for out-of-range addresses.
  logic b_req0 = 1'b0, b_req1 = 1'b0;
  logic [1:0] b_addr0 = '0, b_addr1 = '0;
  logic [7:0] b_data0 = '0, b_data1 = '0;
  logic b_gnt0, b_gnt1, b_busy, b_err;
  logic [2:0] b_pl;
  logic [7:0] b_wdata;

  reg_wr_arbiter #(.NREG(NREG), .W(W)) u_dut (
    .clk(clk), .reset(rst_n),
    .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
    .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
    .pl(pl), .wdata(wdata), .busy(busy), .err(err)
  );

  reg_wr_arbiter #(.NREG(3), .W(8)) u_dut3 (
    .clk(clk), .reset(rst_n),
    .req0(b_req0), .addr0(b_addr0), .data0(b_data0), .gnt0(b_gnt0),
    .req1(b_req1), .addr1(b_addr1), .data1(b_data1), .gnt1(b_gnt1),
    .pl(b_pl), .wdata(b_wdata), .busy(b_busy), .err(b_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {logic [AW-1:0] addr; logic [W-1:0] data;} wr_t;
  typedef struct {bit who; logic [NREG-1:0] pl; logic [W-1:0] wdata; bit err;} exp_t;

  wr_t  q0[$];
  wr_t  q1[$];
  exp_t sb[$];
  int   glog_who[$];
  int   glog_cyc[$];

  logic [W-1:0] bank [NREG] = '{default: '0};
  logic [W-1:0] exp_bank [NREG] = '{default: '0};

  bit m_busy = 1'b0;
  bit m_rr = 1'b0;
  bit pend_v = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  logic [W-1:0] pend_data = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Register bank: each register loads wdata when its strobe is high.
  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) if (pl[i]) bank[i] <= wdata;
  end

  // Reference model: a write occupies two cycles; an idle cycle samples requests and the
  // winner is the lone requester, or the pointer's choice when both request.
  always @(posedge clk or negedge rst_n) begin
    bit who;
    wr_t w;
    exp_t e;
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_rr   <= 1'b0;
      pend_v <= 1'b0;
      sb.delete();
    end else if (m_busy) begin
      m_busy <= 1'b0;
      pend_v <= 1'b0;
      if (pend_v) exp_bank[pend_addr] <= pend_data;
    end else if (req0 || req1) begin
      who = (req0 && req1) ? m_rr : req1;
      if (who) begin w.addr = addr1; w.data = data1; end
      else     begin w.addr = addr0; w.data = data0; end
      e.who   = who;
      e.wdata = w.data;
      e.err   = (int'(w.addr) >= int'(NREG));
      e.pl    = e.err ? '0 : (NREG'(1) << w.addr);
      sb.push_back(e);
      m_rr      <= !who;
      m_busy    <= 1'b1;
      pend_v    <= 1'b1;
      pend_addr <= w.addr;
      pend_data <= w.data;
    end
  end

  // Requesters: present the queue head, retire it once its grant is seen.
  always @(negedge clk) begin
    if (gnt0 && q0.size() > 0) void'(q0.pop_front());
    if (gnt1 && q1.size() > 0) void'(q1.pop_front());
    req0 = q0.size() > 0;
    req1 = q1.size() > 0;
    if (req0) {addr0, data0} = q0[0];
    if (req1) {addr1, data1} = q1[0];
  end

  // Monitor: compare DUT outputs against the scoreboard every cycle.
  always @(negedge clk) begin
    exp_t e;
    bit have;
    if (rst_n) begin
      have = sb.size() > 0;
      chk("busy", busy, have);
      if (gnt0 || gnt1) begin
        glog_who.push_back(gnt1 ? 1 : 0);
        glog_cyc.push_back(cyc);
      end
      if (have) begin
        e = sb.pop_front();
        chk("gnt0", gnt0, !e.who);
        chk("gnt1", gnt1, e.who);
        chk("pl", pl, e.pl);
        chk("wdata", wdata, e.wdata);
        chk("err", err, e.err);
      end else begin
        chk("idle_gnt", {gnt1, gnt0}, 0);
        chk("idle_pl", pl, 0);
        chk("idle_err", err, 0);
      end
    end
  end

  task automatic wait_drain(input int max);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < max) begin
      @(posedge clk);
      n++;
    end
    if (n >= max) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=<%0d cycles", n, max);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_log();
    glog_who.delete();
    glog_cyc.delete();
  endtask

  initial begin
    wr_t w;
    // Reset held while requester 0 is asking.
    q0.push_back('{2'd2, 8'hAA});
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_pl", pl, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_gnt0", gnt0, 1);
    chk("first_gnt1", gnt1, 0);
    chk("first_pl", pl, 4'b0100);
    chk("first_wdata", wdata, 8'hAA);
    chk("first_busy", busy, 1);
    wait_drain(50);
    chk("single_reg2", bank[2], 8'hAA);

    // Contention after reset: requester 0 first, one idle cycle, then requester 1.
    reset_pulse();
    clear_log();
    q0.push_back('{2'd1, 8'h55});
    q1.push_back('{2'd3, 8'h3B});
    wait_drain(50);
    chk("cont_count", glog_who.size(), 2);
    if (glog_who.size() >= 2) begin
      chk("cont_first", glog_who[0], 0);
      chk("cont_second", glog_who[1], 1);
      chk("cont_gap", glog_cyc[1] - glog_cyc[0], 2);
    end
    chk("cont_reg1", bank[1], 8'h55);
    chk("cont_reg3", bank[3], 8'h3B);

    // Fairness: both held continuously for 8 writes.
    reset_pulse();
    clear_log();
    for (int i = 0; i < 4; i++) begin
      w.addr = AW'($urandom_range(0, NREG - 1)); w.data = W'($urandom); q0.push_back(w);
      w.addr = AW'($urandom_range(0, NREG - 1)); w.data = W'($urandom); q1.push_back(w);
    end
    wait_drain(100);
    chk("fair_count", glog_who.size(), 8);
    for (int i = 0; i < glog_who.size(); i++) chk("fair_order", glog_who[i], i % 2);
    for (int i = 1; i < glog_cyc.size(); i++) chk("fair_gap", glog_cyc[i] - glog_cyc[i-1], 2);

    // Same address from both: second write in round-robin order wins.
    reset_pulse();
    q0.push_back('{2'd0, 8'h11});
    q1.push_back('{2'd0, 8'hD4});
    wait_drain(50);
    chk("same_reg0", bank[0], 8'hD4);

    // Reset during a write cycle suppresses the load.
    bank[2] <= 8'hAA;
    exp_bank[2] <= 8'hAA;
    @(negedge clk);
    q1.push_back('{2'd2, 8'h77});
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (gnt1) break;
    end
    chk("midwr_gnt1", gnt1, 1);
    rst_n = 1'b0;
    q1.delete();
    #1;
    chk("midwr_pl", pl, 0);
    chk("midwr_gnt1_clr", gnt1, 0);
    chk("midwr_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    chk("midwr_reg2", bank[2], 8'hAA);

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (q0.size() < 2 && $urandom_range(0, 2) == 0) begin
        w.addr = AW'($urandom_range(0, NREG - 1)); w.data = W'($urandom); q0.push_back(w);
      end
      if (q1.size() < 2 && $urandom_range(0, 2) == 0) begin
        w.addr = AW'($urandom_range(0, NREG - 1)); w.data = W'($urandom); q1.push_back(w);
      end
    end
    wait_drain(200);
    for (int i = 0; i < NREG; i++) chk("rand_bank", bank[i], exp_bank[i]);

    // Out-of-range address on the 3-register instance.
    @(negedge clk);
    b_req1 = 1'b1; b_addr1 = 2'd3; b_data1 = 8'h5A;
    @(posedge clk);
    #1;
    chk("oor_gnt1", b_gnt1, 1);
    chk("oor_gnt0", b_gnt0, 0);
    chk("oor_pl", b_pl, 0);
    chk("oor_err", b_err, 1);
    chk("oor_busy", b_busy, 1);
    b_req1 = 1'b0;
    @(posedge clk);
    #1;
    chk("oor_err_clr", b_err, 0);
    chk("oor_busy_clr", b_busy, 0);
    @(negedge clk);
    b_req1 = 1'b1; b_addr1 = 2'd2; b_data1 = 8'hC3;
    @(posedge clk);
    #1;
    chk("inr_pl", b_pl, 3'b100);
    chk("inr_err", b_err, 0);
    chk("inr_wdata", b_wdata, 8'hC3);
    b_req1 = 1'b0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
